// File: rtl/card_dealer.sv
// Deals non-repeating cards from a 52-card deck using an LFSR seeded
// from the free-running counter, with a dealt-card mask kept until a shuffle.
module card_dealer #(
  parameter int          SEED_WIDTH = 12,
  parameter logic [15:0] LFSR_INIT  = 16'hACE1
) (
  input  logic                  clk_50M,
  input  logic                  i_Reset,
  input  logic [SEED_WIDTH-1:0] i_Seed,
  input  logic                  i_Load_Seed,
  input  logic                  i_Req,
  input  logic                  i_Shuffle,
  output logic [3:0]            o_Card,
  output logic [1:0]            o_Suit,
  output logic [3:0]            o_Value,
  output logic                  o_Valid,
  output logic                  o_Busy,
  output logic                  o_Empty,
  output logic [5:0]            o_Dealt
);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t      state_q;
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic [51:0] mask_q;
  logic [5:0]  idx_q;
  logic [5:0]  start_d;
  logic [3:0]  card_q;
  logic [1:0]  suit_q;
  logic [3:0]  value_q;
  logic        valid_q;
  logic        busy_q;
  logic        empty_q;
  logic [5:0]  dealt_q;
  logic [3:0]  rank_d;
  logic [1:0]  suit_d;
  logic [11:0] seed_ext;

  assign seed_ext = 12'(i_Seed);

  always_comb begin
    lfsr_d = {lfsr_q[14:0],
              lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    if (i_Load_Seed)
      lfsr_d = {4'hA, seed_ext};
  end

  // Fold the 64 possible LFSR values onto the 52 card slots
  always_comb begin
    start_d = lfsr_q[5:0];
    if (lfsr_q[5:0] >= 6'd52)
      start_d = lfsr_q[5:0] - 6'd52;
  end

  always_comb begin
    suit_d = 2'd0;
    rank_d = 4'(idx_q + 6'd1);
    if (idx_q >= 6'd39) begin
      suit_d = 2'd3;
      rank_d = 4'(idx_q - 6'd38);
    end else if (idx_q >= 6'd26) begin
      suit_d = 2'd2;
      rank_d = 4'(idx_q - 6'd25);
    end else if (idx_q >= 6'd13) begin
      suit_d = 2'd1;
      rank_d = 4'(idx_q - 6'd12);
    end
  end

  always_ff @(posedge clk_50M or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_INIT;
      mask_q  <= '0;
      idx_q   <= '0;
      card_q  <= '0;
      suit_q  <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      empty_q <= 1'b0;
      dealt_q <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (i_Shuffle) begin
            mask_q  <= '0;
            dealt_q <= '0;
            empty_q <= 1'b0;
          end else if (i_Req && !empty_q && !busy_q) begin
            idx_q   <= start_d;
            busy_q  <= 1'b1;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (i_Shuffle) begin
            mask_q  <= '0;
            dealt_q <= '0;
            empty_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (mask_q[idx_q]) begin
            idx_q <= (idx_q == 6'd51) ? 6'd0 : idx_q + 6'd1;
          end else begin
            // busy stays high through the strobe cycle
            mask_q[idx_q] <= 1'b1;
            card_q  <= rank_d;
            suit_q  <= suit_d;
            value_q <= (rank_d > 4'd10) ? 4'd10 : rank_d;
            dealt_q <= dealt_q + 6'd1;
            empty_q <= (dealt_q == 6'd51);
            valid_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_Card  = card_q;
  assign o_Suit  = suit_q;
  assign o_Value = value_q;
  assign o_Valid = valid_q;
  assign o_Busy  = busy_q;
  assign o_Empty = empty_q;
  assign o_Dealt = dealt_q;

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: seeded deals, collisions, wrap,
// exhaustion, shuffle and reset behaviour.
module tb_card_dealer;

  logic        clk_50M = 1'b0;
  logic        i_Reset;
  logic [11:0] i_Seed;
  logic        i_Load_Seed;
  logic        i_Req;
  logic        i_Shuffle;
  logic [3:0]  o_Card;
  logic [1:0]  o_Suit;
  logic [3:0]  o_Value;
  logic        o_Valid;
  logic        o_Busy;
  logic        o_Empty;
  logic [5:0]  o_Dealt;

  int total = 0;
  int bad   = 0;

  card_dealer #(.SEED_WIDTH(12), .LFSR_INIT(16'hACE1)) dut (
    .clk_50M    (clk_50M),
    .i_Reset    (i_Reset),
    .i_Seed     (i_Seed),
    .i_Load_Seed(i_Load_Seed),
    .i_Req      (i_Req),
    .i_Shuffle  (i_Shuffle),
    .o_Card     (o_Card),
    .o_Suit     (o_Suit),
    .o_Value    (o_Value),
    .o_Valid    (o_Valid),
    .o_Busy     (o_Busy),
    .o_Empty    (o_Empty),
    .o_Dealt    (o_Dealt)
  );

  always #10 clk_50M = ~clk_50M;

  task automatic tick();
    @(posedge clk_50M);
    #1;
  endtask

  // lat = cycles from request cycle to strobe cycle; 0 on timeout
  task automatic do_req(input bit ld, input logic [11:0] sd,
                        output int lat);
    tick();
    if (ld) begin
      i_Load_Seed = 1'b1;
      i_Seed      = sd;
      tick();
      i_Load_Seed = 1'b0;
    end
    i_Req = 1'b1;
    tick();
    i_Req = 1'b0;
    lat = 1;
    while (!o_Valid && lat < 60) begin
      tick();
      lat++;
    end
    if (!o_Valid) lat = 0;
  endtask

  task automatic test_reset();
    i_Reset = 1'b1;
    i_Seed = '0; i_Load_Seed = 0; i_Req = 0; i_Shuffle = 0;
    tick();
    tick();
    total++;
    if ({o_Card, o_Suit, o_Value, o_Valid, o_Busy, o_Empty, o_Dealt} !== 22'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0",
               {o_Card, o_Suit, o_Value, o_Valid, o_Busy, o_Empty, o_Dealt});
    end
    i_Reset = 1'b0;
    tick();
  endtask

  task automatic test_seeded();
    int lat;
    do_req(1'b1, 12'h005, lat);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL seed_lat got=%0d want=2", lat); end
    total++;
    if ({o_Card, o_Suit, o_Value} !== {4'd6, 2'd0, 4'd6}) begin
      bad++; $display("FAIL seed_card got=%0d/%0d/%0d want=6/0/6", o_Card, o_Suit, o_Value);
    end
    total++;
    if (o_Dealt !== 6'd1 || o_Busy !== 1'b1) begin
      bad++; $display("FAIL seed_dealt got=%0d busy=%b want=1 busy=1", o_Dealt, o_Busy);
    end
    tick();
    total++;
    if (o_Valid !== 1'b0 || o_Busy !== 1'b0 || o_Card !== 4'd6) begin
      bad++; $display("FAIL seed_after valid=%b busy=%b card=%0d want 0 0 6", o_Valid, o_Busy, o_Card);
    end
  endtask

  task automatic test_collision();
    int lat;
    do_req(1'b1, 12'h005, lat);
    total++;
    if (lat !== 3 || o_Card !== 4'd7 || o_Dealt !== 6'd2) begin
      bad++; $display("FAIL coll_next lat=%0d card=%0d dealt=%0d want 3 7 2", lat, o_Card, o_Dealt);
    end
    do_req(1'b1, 12'h03F, lat);
    total++;
    if (lat !== 2 || {o_Card, o_Suit, o_Value} !== {4'd12, 2'd0, 4'd10}) begin
      bad++; $display("FAIL fold lat=%0d card=%0d/%0d/%0d want 2 12/0/10", lat, o_Card, o_Suit, o_Value);
    end
    total++;
    if (o_Dealt !== 6'd3) begin bad++; $display("FAIL fold_dealt got=%0d want=3", o_Dealt); end
  endtask

  task automatic test_wrap();
    int lat;
    do_req(1'b1, 12'h033, lat);
    total++;
    if (lat !== 2 || {o_Card, o_Suit, o_Value} !== {4'd13, 2'd3, 4'd10}) begin
      bad++; $display("FAIL wrap_first lat=%0d card=%0d/%0d/%0d want 2 13/3/10", lat, o_Card, o_Suit, o_Value);
    end
    do_req(1'b1, 12'h033, lat);
    total++;
    if (lat !== 3 || {o_Card, o_Suit, o_Value} !== {4'd1, 2'd0, 4'd1}) begin
      bad++; $display("FAIL wrap_second lat=%0d card=%0d/%0d/%0d want 3 1/0/1", lat, o_Card, o_Suit, o_Value);
    end
    total++;
    if (o_Dealt !== 6'd5) begin bad++; $display("FAIL wrap_dealt got=%0d want=5", o_Dealt); end
  endtask

  task automatic test_reset_mid_scan();
    bit seen;
    tick();
    i_Load_Seed = 1'b1; i_Seed = 12'h005;
    tick();
    i_Load_Seed = 1'b0; i_Req = 1'b1;
    tick();
    i_Req = 1'b0;
    tick();
    total++;
    if (o_Busy !== 1'b1 || o_Valid !== 1'b0) begin
      bad++; $display("FAIL mid_scan busy=%b valid=%b want 1 0", o_Busy, o_Valid);
    end
    #2;
    i_Reset = 1'b1;
    #1;
    total++;
    if ({o_Card, o_Suit, o_Value, o_Valid, o_Busy, o_Empty, o_Dealt} !== 22'd0) begin
      bad++; $display("FAIL async_reset got=%h want=0",
                      {o_Card, o_Suit, o_Value, o_Valid, o_Busy, o_Empty, o_Dealt});
    end
    tick();
    i_Reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (o_Valid || o_Busy) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL reset_no_strobe got=1 want=0"); end
  endtask

  task automatic test_exhaust();
    int lat;
    int idx;
    bit [51:0] seen;
    bit act;
    seen = '0;
    for (int n = 0; n < 52; n++) begin
      do_req(1'b0, 12'h000, lat);
      total++;
      if (lat < 2 || lat > 53) begin
        bad++; $display("FAIL exh_lat n=%0d got=%0d want 2..53", n, lat);
      end
      idx = int'(o_Suit) * 13 + int'(o_Card) - 1;
      total++;
      if (o_Card < 4'd1 || o_Card > 4'd13 || seen[idx]) begin
        bad++; $display("FAIL exh_unique n=%0d card=%0d suit=%0d want fresh", n, o_Card, o_Suit);
      end else begin
        seen[idx] = 1'b1;
      end
      total++;
      if (o_Value !== ((o_Card > 4'd10) ? 4'd10 : o_Card) || o_Dealt !== 6'(n + 1)) begin
        bad++; $display("FAIL exh_value n=%0d value=%0d dealt=%0d", n, o_Value, o_Dealt);
      end
    end
    total++;
    if (seen !== {52{1'b1}} || o_Dealt !== 6'd52 || o_Empty !== 1'b1) begin
      bad++; $display("FAIL exh_full dealt=%0d empty=%b want 52 1", o_Dealt, o_Empty);
    end
    tick();
    i_Req = 1'b1;
    tick();
    i_Req = 1'b0;
    act = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (o_Valid || o_Busy) act = 1'b1;
      tick();
    end
    total++;
    if (act !== 1'b0 || o_Dealt !== 6'd52) begin
      bad++; $display("FAIL exh_53rd active=%b dealt=%0d want 0 52", act, o_Dealt);
    end
  endtask

  task automatic test_shuffle();
    int lat;
    bit act;
    i_Shuffle = 1'b1;
    tick();
    i_Shuffle = 1'b0;
    total++;
    if (o_Empty !== 1'b0 || o_Dealt !== 6'd0) begin
      bad++; $display("FAIL shuf_idle empty=%b dealt=%0d want 0 0", o_Empty, o_Dealt);
    end
    do_req(1'b1, 12'h005, lat);
    total++;
    if (lat !== 2 || o_Card !== 4'd6 || o_Dealt !== 6'd1) begin
      bad++; $display("FAIL shuf_redeal lat=%0d card=%0d dealt=%0d want 2 6 1", lat, o_Card, o_Dealt);
    end
    // abort a deal whose first probe would succeed
    tick();
    i_Load_Seed = 1'b1; i_Seed = 12'h03F;
    tick();
    i_Load_Seed = 1'b0; i_Req = 1'b1;
    tick();
    i_Req = 1'b0; i_Shuffle = 1'b1;
    tick();
    i_Shuffle = 1'b0;
    act = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (o_Valid || o_Busy) act = 1'b1;
      tick();
    end
    total++;
    if (act !== 1'b0 || o_Dealt !== 6'd0 || o_Card !== 4'd6) begin
      bad++; $display("FAIL shuf_abort active=%b dealt=%0d card=%0d want 0 0 6", act, o_Dealt, o_Card);
    end
    i_Shuffle = 1'b1; i_Req = 1'b1;
    tick();
    i_Shuffle = 1'b0; i_Req = 1'b0;
    act = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (o_Valid || o_Busy) act = 1'b1;
      tick();
    end
    total++;
    if (act !== 1'b0 || o_Dealt !== 6'd0) begin
      bad++; $display("FAIL shuf_req_drop active=%b dealt=%0d want 0 0", act, o_Dealt);
    end
    do_req(1'b1, 12'h03F, lat);
    total++;
    if (lat !== 2 || {o_Card, o_Suit, o_Value} !== {4'd12, 2'd0, 4'd10} || o_Dealt !== 6'd1 || o_Empty !== 1'b0) begin
      bad++; $display("FAIL shuf_deal lat=%0d card=%0d/%0d/%0d dealt=%0d empty=%b", lat, o_Card, o_Suit, o_Value, o_Dealt, o_Empty);
    end
  endtask

  initial begin
    test_reset();
    test_seeded();
    test_collision();
    test_wrap();
    test_reset_mid_scan();
    test_exhaust();
    test_shuffle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
